// File: rtl/mxn_logic_sequencer.sv
// Clocked front end for the mXnBits gate bank: loads SETS operand lanes over a
// valid/ready stream, captures the selected gate result, then drains it lane by lane.
module mxn_logic_sequencer #(
    parameter int WIDTH = 4,
    parameter int SETS  = 2,
    parameter int IDX_W = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic [2:0]                in_op,
    output logic [SETS*WIDTH-1:0]     in1_packed,
    output logic [SETS*WIDTH-1:0]     in2_packed,
    input  logic [7*SETS*WIDTH-1:0]   gate_res,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_lane,
    output logic                      out_last,
    output logic                      op_err,
    output logic                      busy
);
    localparam int SW = SETS * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    typedef enum logic [1:0] {LOAD, EXEC, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       op_reg, op_next;
    logic             op_err_reg, op_err_next;
    logic [SW-1:0]    in1_reg, in1_next;
    logic [SW-1:0]    in2_reg, in2_next;
    logic [SW-1:0]    res_reg, res_next;
    logic [SW-1:0]    slice [8];
    logic [SETS-1:0]  lane_load;
    logic             accept;
    logic             last_lane;

    // Slot 7 is the reserved op; it selects an all-zero result.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_slice
            assign slice[gi] = gate_res[gi*SW +: SW];
        end
    endgenerate
    assign slice[7] = '0;

    assign accept    = in_valid && in_ready;
    assign last_lane = (cnt_reg == LAST_IDX);

    generate
        for (gi = 0; gi < SETS; gi++) begin : g_lane
            assign lane_load[gi] = accept && (cnt_reg == IDX_W'(gi));
            assign in1_next[gi*WIDTH +: WIDTH] = lane_load[gi] ? in_a : in1_reg[gi*WIDTH +: WIDTH];
            assign in2_next[gi*WIDTH +: WIDTH] = lane_load[gi] ? in_b : in2_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= LOAD;
            cnt_reg    <= '0;
            op_reg     <= '0;
            op_err_reg <= 1'b0;
            in1_reg    <= '0;
            in2_reg    <= '0;
            res_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            op_err_reg <= op_err_next;
            in1_reg    <= in1_next;
            in2_reg    <= in2_next;
            res_reg    <= res_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        op_err_next = op_err_reg;
        res_next    = res_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_lane    = '0;
        out_last    = 1'b0;

        case (state_reg)
            LOAD: begin
                // Held low while reset is asserted so no beat looks accepted.
                in_ready = rst_n;
                if (accept) begin
                    if (cnt_reg == '0) begin
                        op_next = in_op;
                    end
                    if (last_lane) begin
                        cnt_next   = '0;
                        state_next = EXEC;
                    end else begin
                        cnt_next = cnt_reg + IDX_W'(1);
                    end
                end
            end
            EXEC: begin
                res_next    = slice[op_reg];
                op_err_next = (op_reg == 3'd7);
                state_next  = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = res_reg[cnt_reg*WIDTH +: WIDTH];
                out_lane  = cnt_reg;
                out_last  = last_lane;
                if (out_ready) begin
                    if (last_lane) begin
                        cnt_next    = '0;
                        op_err_next = 1'b0;
                        state_next  = LOAD;
                    end else begin
                        cnt_next = cnt_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign in1_packed = in1_reg;
    assign in2_packed = in2_reg;
    assign op_err     = op_err_reg;
    assign busy       = (state_reg != LOAD) || (cnt_reg != '0);

endmodule

// File: tb/tb_mxn_logic_sequencer.sv
// Bench for mxn_logic_sequencer: a behavioural gate bank feeds gate_res, and a
// scoreboard queue holds the expected drained lanes of each loaded batch.
module tb_mxn_logic_sequencer;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [2:0]  in_op;
    logic [7:0]  in1_packed;
    logic [7:0]  in2_packed;
    logic [55:0] gate_res;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [0:0]  out_lane;
    logic        out_last;
    logic        op_err;
    logic        busy;

    typedef struct packed {
        logic [3:0] data;
        logic [0:0] lane;
        logic       last;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mxn_logic_sequencer #(.WIDTH(4), .SETS(2), .IDX_W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in1_packed (in1_packed),
        .in2_packed (in2_packed),
        .gate_res   (gate_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .op_err     (op_err),
        .busy       (busy)
    );

    // Behavioural mXnBits bank: slices NOT, AND, OR, NAND, NOR, XOR, XNOR from LSB.
    always_comb begin
        gate_res = {~(in1_packed ^ in2_packed), in1_packed ^ in2_packed,
                    ~(in1_packed | in2_packed), ~(in1_packed & in2_packed),
                    in1_packed | in2_packed, in1_packed & in2_packed, ~in1_packed};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 4'h0;
        endcase
    endfunction

    // Output monitor: one line per accepted result lane.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got data=%h lane=%0d with no pending result", out_data, out_lane);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || out_lane !== e.lane || out_last !== e.last || op_err !== e.err) begin
                    bad++;
                    $display("FAIL lane_result got data=%h lane=%0d last=%b err=%b want data=%h lane=%0d last=%b err=%b",
                             out_data, out_lane, out_last, op_err, e.data, e.lane, e.last, e.err);
                end else begin
                    $display("txn lane=%0d data=%h last=%b err=%b", out_lane, out_data, out_last, op_err);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got in_ready=%b want 1 within 200 cycles", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_batch(input logic [7:0] a_pk, input logic [7:0] b_pk,
                              input logic [2:0] op0, input logic [2:0] op1, input bit drop);
        exp_t e;
        send_beat(a_pk[3:0], b_pk[3:0], op0);
        send_beat(a_pk[7:4], b_pk[7:4], op1);
        for (int l = 0; l < 2; l++) begin
            e.data = model(op0, a_pk[l*4 +: 4], b_pk[l*4 +: 4]);
            e.lane = l[0:0];
            e.last = (l == 1);
            e.err  = (op0 == 3'd7);
            sb.push_back(e);
        end
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL idle_timeout got busy=%b pending=%0d want idle", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready, busy, op_err, out_last, out_lane, out_data, in1_packed, in2_packed} !== 26'h0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b rdy=%b busy=%b err=%b last=%b lane=%0d data=%h in1=%h in2=%h want all 0",
                     out_valid, in_ready, busy, op_err, out_last, out_lane, out_data, in1_packed, in2_packed);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_and();
        send_batch(8'h3C, 8'h5A, 3'd1, 3'd1, 1'b1);
        total++;
        if (in1_packed !== 8'h3C || in2_packed !== 8'h5A) begin
            bad++;
            $display("FAIL and_packed got in1=%h in2=%h want 3c 5a", in1_packed, in2_packed);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL and_exec_cycle got valid=%b busy=%b want 0 1", out_valid, busy);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h8 || out_lane !== 1'b0) begin
            bad++;
            $display("FAIL and_latency got valid=%b data=%h lane=%0d want 1 8 0", out_valid, out_data, out_lane);
        end
        wait_idle();
    endtask

    task automatic test_op_change();
        send_batch(8'h3C, 8'h5A, 3'd5, 3'd0, 1'b1);
        wait_idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_batch(8'h3C, 8'h5A, 3'd1, 3'd1, 1'b0);
        @(negedge clk);
        in_a = 4'hF;
        in_b = 4'hF;
        in_op = 3'd2;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 4'h8 || out_lane !== 1'b0 || in_ready !== 1'b0 ||
                in1_packed !== 8'h3C || in2_packed !== 8'h5A) begin
                bad++;
                $display("FAIL stall_hold cyc%0d got valid=%b data=%h lane=%0d rdy=%b in1=%h in2=%h want 1 8 0 0 3c 5a",
                         i, out_valid, out_data, out_lane, in_ready, in1_packed, in2_packed);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        total++;
        if (in1_packed !== 8'h3C || in2_packed !== 8'h5A) begin
            bad++;
            $display("FAIL stall_no_load got in1=%h in2=%h want 3c 5a", in1_packed, in2_packed);
        end
    endtask

    task automatic test_op7();
        out_ready = 1'b0;
        send_batch(8'h12, 8'h34, 3'd7, 3'd7, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (op_err !== 1'b1 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL op7_err_drain got err=%b valid=%b want 1 1", op_err, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (op_err !== 1'b1 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL op7_err_last got err=%b last=%b want 1 1", op_err, out_last);
        end
        @(negedge clk);
        total++;
        if (op_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL op7_err_clear got err=%b busy=%b want 0 0", op_err, busy);
        end
    endtask

    task automatic test_reset_drain();
        int n;
        out_ready = 1'b0;
        send_batch(8'h96, 8'hA5, 3'd2, 3'd2, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in1_packed !== 8'h00 || in2_packed !== 8'h00 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drain got valid=%b in1=%h in2=%h rdy=%b want 0 00 00 0",
                     out_valid, in1_packed, in2_packed, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_release got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        int prev;
        logic [7:0] p;
        prev = -1;
        out_ready = 1'b1;
        for (int op = 0; op < 7; op++) begin
            for (int k = 0; k < 256; k++) begin
                p = k[7:0];
                send_batch({p[3:0], p[7:4]}, {p[7:4], p[3:0]}, op[2:0], op[2:0], 1'b0);
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev != 5) begin
                        bad++;
                        $display("FAIL batch_period op=%0d pair=%h got %0d want 5", op, p, cyc - prev);
                    end
                end
                prev = cyc;
            end
        end
        in_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_and();
        test_op_change();
        test_backpressure();
        test_op7();
        test_reset_drain();
        test_exhaustive();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
